// File: rtl/snn_pkg.sv
// Shared types and helpers for the SNN output readout: FSM state encoding,
// default sizing constants and a saturating increment.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_N_CH  = 4;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_WIN_W = 16;

  // Increment that sticks at 2^width-1; width must stay below 32.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_val;
    max_val = (32'd1 << width) - 32'd1;
    return (value >= max_val) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/spike_counter.sv
// One saturating spike counter with synchronous clear and count enable.
module spike_counter
  import snn_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en) begin
      count_next = CNT_W'(sat_inc(32'(count_reg), CNT_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/spike_window_decoder.sv
// Counts spikes per output channel over a programmable window, then scans the
// counts one channel per cycle to pick the winning class (lowest index on ties).
module spike_window_decoder
  import snn_pkg::*;
#(
  parameter  int N_CH  = DEF_N_CH,
  parameter  int CNT_W = DEF_CNT_W,
  parameter  int WIN_W = DEF_WIN_W,
  localparam int IDX_W = $clog2(N_CH),
  localparam int TOT_W = CNT_W + IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIN_W-1:0] window_len,
  input  logic [N_CH-1:0]  spike_in,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [IDX_W-1:0] class_idx,
  output logic [CNT_W-1:0] max_count,
  output logic [TOT_W-1:0] total_count,
  output logic             no_spike
);

  state_t state_reg, state_next;

  logic [WIN_W-1:0] win_reg;
  logic [WIN_W-1:0] win_cnt_reg;
  logic [IDX_W-1:0] scan_idx_reg;
  logic [CNT_W-1:0] run_max_reg;
  logic [IDX_W-1:0] run_idx_reg;
  logic [TOT_W-1:0] run_total_reg;

  logic [IDX_W-1:0] class_idx_reg;
  logic [CNT_W-1:0] max_count_reg;
  logic [TOT_W-1:0] total_count_reg;
  logic             no_spike_reg;

  logic [CNT_W-1:0] counts [N_CH];
  logic             start_acc;
  logic             counting;
  logic             win_last;
  logic             scan_last;
  logic [CNT_W-1:0] cur_cnt;
  logic             take_new;
  logic [CNT_W-1:0] max_next;
  logic [IDX_W-1:0] idx_next;
  logic [TOT_W-1:0] total_next;

  assign start_acc = (state_reg == IDLE) && start;
  assign counting  = (state_reg == COUNT);
  assign win_last  = (win_cnt_reg == win_reg - WIN_W'(1));
  assign scan_last = (scan_idx_reg == IDX_W'(N_CH - 1));

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      spike_counter #(
        .CNT_W(CNT_W)
      ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_acc),
        .en   (counting && spike_in[gi]),
        .count(counts[gi])
      );
    end
  endgenerate

  // Strictly-greater update keeps the earliest channel on ties.
  always_comb begin
    cur_cnt    = counts[scan_idx_reg];
    take_new   = (cur_cnt > run_max_reg);
    max_next   = take_new ? cur_cnt : run_max_reg;
    idx_next   = take_new ? scan_idx_reg : run_idx_reg;
    total_next = run_total_reg + TOT_W'(cur_cnt);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = COUNT;
      COUNT:   if (win_last) state_next = SCAN;
      SCAN:    if (scan_last) state_next = DONE;
      DONE:    if (result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      win_reg         <= '0;
      win_cnt_reg     <= '0;
      scan_idx_reg    <= '0;
      run_max_reg     <= '0;
      run_idx_reg     <= '0;
      run_total_reg   <= '0;
      class_idx_reg   <= '0;
      max_count_reg   <= '0;
      total_count_reg <= '0;
      no_spike_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start_acc) begin
        win_reg       <= (window_len == '0) ? WIN_W'(1) : window_len;
        win_cnt_reg   <= '0;
        scan_idx_reg  <= '0;
        run_max_reg   <= '0;
        run_idx_reg   <= '0;
        run_total_reg <= '0;
      end
      if (state_reg == COUNT) begin
        win_cnt_reg <= win_cnt_reg + WIN_W'(1);
      end
      if (state_reg == SCAN) begin
        scan_idx_reg  <= scan_idx_reg + IDX_W'(1);
        run_max_reg   <= max_next;
        run_idx_reg   <= idx_next;
        run_total_reg <= total_next;
        // Final channel folds straight into the result so DONE shows it at once.
        if (scan_last) begin
          class_idx_reg   <= idx_next;
          max_count_reg   <= max_next;
          total_count_reg <= total_next;
          no_spike_reg    <= (max_next == '0);
        end
      end
    end
  end

  assign busy         = (state_reg != IDLE);
  assign result_valid = (state_reg == DONE);
  assign class_idx    = class_idx_reg;
  assign max_count    = max_count_reg;
  assign total_count  = total_count_reg;
  assign no_spike     = no_spike_reg;

endmodule

// File: tb/tb_spike_window_decoder.sv
// Scoreboard bench for spike_window_decoder: a reference model predicts each
// window's result when stimulus is driven; results are compared on handshake.
module tb_spike_window_decoder;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;
  localparam int WIN_W = 16;
  localparam int IDX_W = 2;
  localparam int TOT_W = CNT_W + IDX_W;
  localparam int CMAX  = 255;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIN_W-1:0] window_len;
  logic [N_CH-1:0]  spike_in;
  logic             busy;
  logic             result_valid;
  logic             result_ready;
  logic [IDX_W-1:0] class_idx;
  logic [CNT_W-1:0] max_count;
  logic [TOT_W-1:0] total_count;
  logic             no_spike;

  typedef struct {
    int cls;
    int mx;
    int tot;
    int nsp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   txn      = 0;
  int   model_cnt [N_CH];

  spike_window_decoder #(
    .N_CH (N_CH),
    .CNT_W(CNT_W),
    .WIN_W(WIN_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .window_len  (window_len),
    .spike_in    (spike_in),
    .busy        (busy),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .class_idx   (class_idx),
    .max_count   (max_count),
    .total_count (total_count),
    .no_spike    (no_spike)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic [N_CH-1:0] gen_spike(input int mode, input int i, input logic [N_CH-1:0] vec);
    case (mode)
      0:       return vec;
      1:       return (i < 5) ? 4'b1010 : 4'b0000;
      default: return N_CH'($urandom);
    endcase
  endfunction

  task automatic run_window(input int wlen, input int mode, input logic [N_CH-1:0] vec,
                            input int bp_cycles, input string name);
    int             w;
    int             n;
    exp_t           e;
    exp_t           got;
    logic [N_CH-1:0] s;
    logic [31:0]    snap_cls, snap_max, snap_tot;
    w = (wlen == 0) ? 1 : wlen;
    for (int c = 0; c < N_CH; c++) model_cnt[c] = 0;

    @(negedge clk);
    start      = 1'b1;
    window_len = WIN_W'(wlen);
    @(posedge clk);
    #1;
    start      = 1'b0;
    window_len = WIN_W'($urandom);
    check({name, "_busy_rise"}, 32'(busy), 1);

    for (int i = 0; i < w; i++) begin
      s = gen_spike(mode, i, vec);
      spike_in = s;
      for (int c = 0; c < N_CH; c++)
        if (s[c] && model_cnt[c] < CMAX) model_cnt[c]++;
      if (bp_cycles > 0 && i == w / 2) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    spike_in = N_CH'($urandom);

    e.cls = 0;
    e.mx  = model_cnt[0];
    e.tot = 0;
    for (int c = 0; c < N_CH; c++) begin
      e.tot += model_cnt[c];
      if (model_cnt[c] > e.mx) begin
        e.mx  = model_cnt[c];
        e.cls = c;
      end
    end
    e.nsp = (e.mx == 0) ? 1 : 0;
    sb.push_back(e);

    if (bp_cycles > 0) result_ready = 1'b0;
    n = w;
    @(negedge clk);
    while (!result_valid && n < w + N_CH + 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({name, "_latency"}, n, w + N_CH);

    if (bp_cycles > 0) begin
      snap_cls = 32'(class_idx);
      snap_max = 32'(max_count);
      snap_tot = 32'(total_count);
      for (int j = 0; j < bp_cycles; j++) begin
        check({name, "_bp_busy"}, 32'(busy), 1);
        check({name, "_bp_valid"}, 32'(result_valid), 1);
        check({name, "_bp_class"}, 32'(class_idx), snap_cls);
        check({name, "_bp_max"}, 32'(max_count), snap_max);
        check({name, "_bp_total"}, 32'(total_count), snap_tot);
        start = (j == 2);
        @(posedge clk);
        @(negedge clk);
      end
      start = 1'b0;
      result_ready = 1'b1;
    end

    // Handshake cycle: a start pulse here must be ignored.
    check({name, "_valid"}, 32'(result_valid), 1);
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 0, 1);
    end else begin
      got = sb.pop_front();
      check({name, "_class_idx"}, 32'(class_idx), got.cls);
      check({name, "_max_count"}, 32'(max_count), got.mx);
      check({name, "_total_count"}, 32'(total_count), got.tot);
      check({name, "_no_spike"}, 32'(no_spike), got.nsp);
      txn++;
      $display("txn %0d %s: win=%0d class=%0d max=%0d total=%0d no_spike=%0d (exp %0d/%0d/%0d/%0d)",
               txn, name, w, class_idx, max_count, total_count, no_spike,
               got.cls, got.mx, got.tot, got.nsp);
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check({name, "_idle_busy"}, 32'(busy), 0);
    check({name, "_idle_valid"}, 32'(result_valid), 0);
    check({name, "_hold_max"}, 32'(max_count), e.mx);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen_valid;
    rst          = 1'b1;
    start        = 1'b0;
    result_ready = 1'b1;
    window_len   = '0;
    spike_in     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(result_valid), 0);
    check("rst_class", 32'(class_idx), 0);
    check("rst_max", 32'(max_count), 0);
    check("rst_total", 32'(total_count), 0);
    check("rst_no_spike", 32'(no_spike), 0);

    run_window(10, 0, 4'b0100, 0, "basic");
    run_window(20, 1, 4'b0000, 0, "tie");
    run_window(8, 0, 4'b0000, 0, "zero");
    run_window(300, 0, 4'b0001, 0, "sat");
    run_window(0, 0, 4'b0010, 0, "zero_win");
    run_window(12, 2, 4'b0000, 7, "backpressure");

    // Abort a window mid-COUNT with reset.
    @(negedge clk);
    start      = 1'b1;
    window_len = 16'd10;
    @(posedge clk);
    #1;
    start    = 1'b0;
    spike_in = 4'b1111;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_valid", 32'(result_valid), 0);
    check("abort_max_cleared", 32'(max_count), 0);
    seen_valid = 0;
    repeat (20) begin
      @(negedge clk);
      if (result_valid) seen_valid = 1;
    end
    check("abort_no_result", seen_valid, 0);
    run_window(3, 0, 4'b0001, 0, "after_rst");

    // Reset and start together: reset wins.
    @(negedge clk);
    rst        = 1'b1;
    start      = 1'b1;
    window_len = 16'd5;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_start_busy", 32'(busy), 0);

    for (int r = 0; r < 4; r++)
      run_window(int'($urandom_range(1, 40)), 2, 4'b0000, 0, "rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
